dm9000a_bus_responder: RTL and testbench

DM9000A_BUS_RESPONDER -- requirements
Module: dm9000a_bus_responder

---
 rtl/dm9000a_pkg.sv | 26 ++
 rtl/dm9000a_loop_fifo.sv | 59 +++++
 rtl/dm9000a_bus_responder.sv | 218 +++++++++++++++++++++
 tb/tb_dm9000a_bus_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dm9000a_pkg.sv
// Shared register map constants and types for the DM9000A bus responder.
package dm9000a_pkg;

  localparam logic [7:0] IDX_VIDL   = 8'h28;
  localparam logic [7:0] IDX_VIDH   = 8'h29;
  localparam logic [7:0] IDX_PIDL   = 8'h2A;
  localparam logic [7:0] IDX_PIDH   = 8'h2B;
  localparam logic [7:0] IDX_MRCMDX = 8'hF0;
  localparam logic [7:0] IDX_MRCMD  = 8'hF2;
  localparam logic [7:0] IDX_MWCMD  = 8'hF8;
  localparam logic [7:0] IDX_ISR    = 8'hFE;
  localparam logic [7:0] IDX_IMR    = 8'hFF;

  localparam logic [15:0] VID = 16'h0A46;
  localparam logic [15:0] PID = 16'h9000;

  typedef enum logic {
    RD_IDLE,
    RD_ACTIVE
  } rd_state_e;

  function automatic logic is_gen_reg(input logic [7:0] idx);
    return idx[7:4] == 4'h0;
  endfunction

endpackage

// File: rtl/dm9000a_loop_fifo.sv
// Synchronous first-word-fall-through loopback FIFO; pointers wrap modulo DEPTH.
module dm9000a_loop_fifo #(
  parameter int unsigned DEPTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic [15:0] wdata_i,
  input  logic        pop_i,
  output logic [15:0] rdata_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dm9000a_bus_responder.sv
// DM9000A-style host bus slave: synchronised async strobes, index/data register
// ports, VID/PID identification and a loopback FIFO with overflow interrupt.
module dm9000a_bus_responder
  import dm9000a_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iENET_CS_N,
  input  logic        iENET_CMD,
  input  logic        iENET_RD_N,
  input  logic        iENET_WR_N,
  input  logic [15:0] iENET_DATA,
  output logic [15:0] oENET_DATA,
  output logic        oENET_DATA_OE,
  output logic        oENET_INT
);

  localparam logic [3:0] SETTLE = 4'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] cs_sync_q, cmd_sync_q, rd_sync_q, wr_sync_q;
  logic [15:0] data_q;
  logic        cs_s, cmd_s, rd_s, wr_s;
  logic        rd_prev_q, wr_prev_q, cmd_prev_q;
  logic [3:0]  settle_q;
  logic        settled;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cs_sync_q  <= '1;
      rd_sync_q  <= '1;
      wr_sync_q  <= '1;
      cmd_sync_q <= '0;
      data_q     <= '0;
    end else begin
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], iENET_CS_N};
      rd_sync_q  <= {rd_sync_q[SYNC_STAGES-2:0], iENET_RD_N};
      wr_sync_q  <= {wr_sync_q[SYNC_STAGES-2:0], iENET_WR_N};
      cmd_sync_q <= {cmd_sync_q[SYNC_STAGES-2:0], iENET_CMD};
      data_q     <= iENET_DATA;
    end
  end

  assign cs_s  = cs_sync_q[SYNC_STAGES-1];
  assign rd_s  = rd_sync_q[SYNC_STAGES-1];
  assign wr_s  = wr_sync_q[SYNC_STAGES-1];
  assign cmd_s = cmd_sync_q[SYNC_STAGES-1];

  // Edge detection stays blind until the reset-value ones have flushed out of
  // the synchronisers, so a strobe held low across reset is never taken as fresh.
  assign settled = (settle_q == '0);

  logic wr_fall, wr_rise, rd_fall, rd_rise;
  logic wr_armed_q, wr_armed_d;
  logic wr_evt;

  assign wr_fall = settled & ~wr_s & wr_prev_q & ~cs_s;
  assign wr_rise = settled & wr_s & ~wr_prev_q;
  assign rd_fall = settled & ~rd_s & rd_prev_q & ~cs_s;
  assign rd_rise = settled & rd_s & ~rd_prev_q;
  assign wr_evt  = wr_rise & wr_armed_q & ~cs_s;

  always_comb begin
    wr_armed_d = wr_armed_q;
    if (wr_fall)      wr_armed_d = 1'b1;
    else if (wr_rise) wr_armed_d = 1'b0;
  end

  logic [7:0]  idx_q, idx_d;
  logic [7:0]  gen_q [16];
  logic        gen_we;
  logic [1:0]  imr_q, imr_d;
  logic        ovf_q, ovf_d, ovf_set, ovf_clr;
  logic        push, pop;
  logic        fifo_full, fifo_empty;
  logic [15:0] fifo_head;

  always_comb begin
    idx_d   = idx_q;
    imr_d   = imr_q;
    gen_we  = 1'b0;
    push    = 1'b0;
    ovf_set = 1'b0;
    ovf_clr = 1'b0;
    if (wr_evt) begin
      if (!cmd_prev_q) begin
        idx_d = data_q[7:0];
      end else if (is_gen_reg(idx_q)) begin
        gen_we = 1'b1;
      end else begin
        case (idx_q)
          IDX_MWCMD: begin
            if (fifo_full) ovf_set = 1'b1;
            else           push    = 1'b1;
          end
          IDX_ISR: ovf_clr = data_q[1];
          IDX_IMR: imr_d   = data_q[1:0];
          default: ;
        endcase
      end
    end
    ovf_d = ovf_set | (ovf_q & ~ovf_clr);
  end

  logic [15:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    if (!cmd_s) begin
      rd_mux = {8'h00, idx_q};
    end else if (is_gen_reg(idx_q)) begin
      rd_mux = {8'h00, gen_q[idx_q[3:0]]};
    end else begin
      case (idx_q)
        IDX_VIDL:   rd_mux = {8'h00, VID[7:0]};
        IDX_VIDH:   rd_mux = {8'h00, VID[15:8]};
        IDX_PIDL:   rd_mux = {8'h00, PID[7:0]};
        IDX_PIDH:   rd_mux = {8'h00, PID[15:8]};
        IDX_MRCMDX,
        IDX_MRCMD:  rd_mux = fifo_empty ? 16'h0000 : fifo_head;
        IDX_ISR:    rd_mux = {14'b0, ovf_q, ~fifo_empty};
        IDX_IMR:    rd_mux = {14'b0, imr_q};
        default:    rd_mux = '0;
      endcase
    end
  end

  rd_state_e   state_q, state_d;
  logic [15:0] rdata_q, rdata_d;
  logic        oe_q, oe_d;
  logic        pend_q, pend_d;
  logic        int_q, int_d;

  // The MRCMD pop is deferred to the RD_N release so the host sees a stable word.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    pop     = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (rd_fall) begin
          state_d = RD_ACTIVE;
          if (cmd_s && idx_q == IDX_MRCMD && !fifo_empty) pend_d = 1'b1;
        end
      end
      RD_ACTIVE: if (rd_s || cs_s) state_d = RD_IDLE;
      default:   state_d = RD_IDLE;
    endcase
    if (pend_q && rd_rise) begin
      pop    = 1'b1;
      pend_d = 1'b0;
    end
    oe_d    = (state_d == RD_ACTIVE);
    rdata_d = '0;
    if (state_d == RD_ACTIVE) rdata_d = (state_q == RD_IDLE) ? rd_mux : rdata_q;
    int_d   = |({ovf_q, ~fifo_empty} & imr_q);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rd_prev_q  <= 1'b1;
      wr_prev_q  <= 1'b1;
      cmd_prev_q <= 1'b0;
      settle_q   <= SETTLE;
      wr_armed_q <= 1'b0;
      idx_q      <= '0;
      imr_q      <= '0;
      ovf_q      <= 1'b0;
      state_q    <= RD_IDLE;
      rdata_q    <= '0;
      oe_q       <= 1'b0;
      pend_q     <= 1'b0;
      int_q      <= 1'b0;
    end else begin
      rd_prev_q  <= rd_s;
      wr_prev_q  <= wr_s;
      cmd_prev_q <= cmd_s;
      if (!settled) settle_q <= settle_q - 1'b1;
      wr_armed_q <= wr_armed_d;
      idx_q      <= idx_d;
      imr_q      <= imr_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      oe_q       <= oe_d;
      pend_q     <= pend_d;
      int_q      <= int_d;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int unsigned i = 0; i < 16; i++) gen_q[i] <= '0;
    end else if (gen_we) begin
      gen_q[idx_q[3:0]] <= data_q[7:0];
    end
  end

  dm9000a_loop_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (iCLK),
    .rst_i   (iRST),
    .push_i  (push),
    .wdata_i (data_q),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign oENET_DATA    = rdata_q;
  assign oENET_DATA_OE = oe_q;
  assign oENET_INT     = int_q;

endmodule

// File: tb/tb_dm9000a_bus_responder.sv
// Directed bench for dm9000a_bus_responder: vector table plus hand sequences.
module tb_dm9000a_bus_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_n = 1'b1;
  logic        cmd = 1'b0;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        oe;
  logic        intr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dm9000a_bus_responder #(
    .FIFO_DEPTH(32),
    .SYNC_STAGES(2)
  ) dut (
    .iCLK          (clk),
    .iRST          (rst),
    .iENET_CS_N    (cs_n),
    .iENET_CMD     (cmd),
    .iENET_RD_N    (rd_n),
    .iENET_WR_N    (wr_n),
    .iENET_DATA    (wdata),
    .oENET_DATA    (rdata),
    .oENET_DATA_OE (oe),
    .oENET_INT     (intr)
  );

  typedef struct {
    int          op;   // 0 write, 1 read, 2 interrupt level
    logic        cmd;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int op, input logic c, input logic [15:0] d,
                              input logic [15:0] e);
    vec_t v;
    v.op = op; v.cmd = c; v.data = d; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic c, input logic [15:0] d);
    @(negedge clk);
    cs_n = 1'b0; cmd = c; wdata = d;
    idle(2);
    wr_n = 1'b0;
    idle(6);
    wr_n = 1'b1;
    idle(6);
    cs_n = 1'b1;
    idle(4);
  endtask

  task automatic bus_read(input logic c, output logic [15:0] d, output logic o);
    @(negedge clk);
    cs_n = 1'b0; cmd = c;
    idle(2);
    rd_n = 1'b0;
    idle(5);
    d = rdata;
    o = oe;
    rd_n = 1'b1;
    idle(6);
    cs_n = 1'b1;
    idle(4);
  endtask

  task automatic read_chk(input string name, input logic c, input logic [15:0] exp);
    logic [15:0] d;
    logic o;
    bus_read(c, d, o);
    check(name, d, exp);
    check({name, "_oe"}, {15'b0, o}, 16'h0001);
  endtask

  initial begin
    logic [15:0] d;
    logic o;

    // Register/ID access, IMR and loopback FIFO ordering
    add(2, 0, 0, 16'h0000);
    add(0, 0, 16'h0005, 0); add(0, 1, 16'h00A5, 0);
    add(1, 1, 0, 16'h00A5); add(1, 0, 0, 16'h0005);
    add(0, 0, 16'h000F, 0); add(0, 1, 16'hABCD, 0); add(1, 1, 0, 16'h00CD);
    add(0, 0, 16'h0010, 0); add(0, 1, 16'h0077, 0); add(1, 1, 0, 16'h0000);
    add(0, 0, 16'h0028, 0); add(1, 1, 0, 16'h0046);
    add(0, 0, 16'h0029, 0); add(1, 1, 0, 16'h000A);
    add(0, 0, 16'h002A, 0); add(1, 1, 0, 16'h0000);
    add(0, 0, 16'h002B, 0); add(1, 1, 0, 16'h0090);
    add(0, 0, 16'h0040, 0); add(1, 1, 0, 16'h0000);
    add(0, 0, 16'h00FF, 0); add(0, 1, 16'h0001, 0); add(1, 1, 0, 16'h0001);
    add(2, 0, 0, 16'h0000);
    add(0, 0, 16'h00F8, 0); add(0, 1, 16'h1234, 0); add(0, 1, 16'h5678, 0);
    add(2, 0, 0, 16'h0001);
    add(0, 0, 16'h00FE, 0); add(1, 1, 0, 16'h0001); add(1, 0, 0, 16'h00FE);
    add(0, 0, 16'h00F0, 0); add(1, 1, 0, 16'h1234); add(1, 1, 0, 16'h1234);
    add(0, 0, 16'h00F2, 0); add(1, 1, 0, 16'h1234); add(1, 1, 0, 16'h5678);
    add(0, 0, 16'h00FE, 0); add(1, 1, 0, 16'h0000);
    add(2, 0, 0, 16'h0000);

    idle(3);
    check("rst_data", rdata, 16'h0000);
    check("rst_oe", {15'b0, oe}, 16'h0000);
    check("rst_int", {15'b0, intr}, 16'h0000);
    rst = 1'b0;
    idle(6);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        0: bus_write(vecs[i].cmd, vecs[i].data);
        1: read_chk($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].exp);
        default: check($sformatf("vec%0d_int", i), {15'b0, intr}, vecs[i].exp);
      endcase
    end

    // Overflow on the 33rd word, W1C of ISR bit1, drain, empty MRCMD
    bus_write(0, 16'h00F8);
    for (int i = 0; i < 33; i++) bus_write(1, 16'h0100 + 16'(i));
    bus_write(0, 16'h00FE);
    read_chk("isr_ovf", 1, 16'h0003);
    check("int_ovf", {15'b0, intr}, 16'h0001);
    bus_write(1, 16'h0002);
    read_chk("isr_w1c", 1, 16'h0001);
    bus_write(0, 16'h00F2);
    for (int i = 0; i < 32; i++) read_chk($sformatf("drain%0d", i), 1, 16'h0100 + 16'(i));
    read_chk("mrcmd_empty", 1, 16'h0000);
    bus_write(0, 16'h00FE);
    read_chk("isr_empty", 1, 16'h0000);
    bus_write(0, 16'h00F8);
    bus_write(1, 16'hBEEF);
    bus_write(0, 16'h00F0);
    read_chk("mrcmdx_after_empty", 1, 16'hBEEF);
    check("int_refill", {15'b0, intr}, 16'h0001);

    // Reset in the middle of an MRCMD read
    bus_write(0, 16'h00F2);
    @(negedge clk);
    cs_n = 1'b0; cmd = 1'b1;
    idle(2);
    rd_n = 1'b0;
    idle(5);
    check("pre_rst_oe", {15'b0, oe}, 16'h0001);
    check("pre_rst_data", rdata, 16'hBEEF);
    rst = 1'b1;
    idle(1);
    check("abort_oe", {15'b0, oe}, 16'h0000);
    check("abort_data", rdata, 16'h0000);
    check("abort_int", {15'b0, intr}, 16'h0000);
    idle(1);
    rst = 1'b0;
    idle(8);
    check("post_rst_no_access", {15'b0, oe}, 16'h0000);
    rd_n = 1'b1;
    idle(6);
    cs_n = 1'b1;
    idle(4);
    bus_write(0, 16'h00FE);
    read_chk("post_rst_isr", 1, 16'h0000);
    check("post_rst_int", {15'b0, intr}, 16'h0000);

    // WR_N toggles with CS_N high must not touch any register
    bus_write(0, 16'h0003);
    bus_write(1, 16'h0055);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cmd = (k == 0); wdata = (k == 0) ? 16'h00AA : 16'h0007;
      idle(2);
      wr_n = 1'b0;
      idle(6);
      wr_n = 1'b1;
      idle(6);
    end
    read_chk("cs_hi_index", 0, 16'h0003);
    read_chk("cs_hi_reg", 1, 16'h0055);

    bus_read(0, d, o);
    check("final_index", d, 16'h0003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
